uart_instr_loader: RTL and testbench

//  Sits downstream of the UART receiver and upstream of the MIPS instruction memory.

---
 rtl/mips_loader_pkg.sv | 18 +
 rtl/uart_instr_loader.sv | 135 +++++++++++++
 tb/tb_uart_instr_loader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_loader_pkg.sv
// Shared loader definitions: FSM states and the host protocol byte values
// used by the loader, the host script and the debug unit.
package mips_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RECV,
      ST_WRITE,
      ST_ACK,
      ST_DONE
   } state_t;

   localparam logic [7:0]  LOAD_CMD   = 8'h4C;
   localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
   localparam logic [7:0]  ACK_CODE   = 8'h06;
   localparam logic [7:0]  ERR_CODE   = 8'h15;

endpackage

// File: rtl/uart_instr_loader.sv
// Collects UART bytes into 32-bit instructions, writes them to instruction memory
// from address 0, gates the CPU until loading ends and reports ACK/ERR to the host.
import mips_loader_pkg::*;

module uart_instr_loader #(
   parameter int unsigned         NB_BYTE   = 8,
   parameter int unsigned         NB_DATA   = 32,
   parameter int unsigned         NB_ADDR   = 32,
   parameter int unsigned         MEM_WORDS = 256,
   parameter logic [NB_BYTE-1:0]  CMD_LOAD  = LOAD_CMD,
   parameter logic [NB_DATA-1:0]  HALT_WORD = HALT_INSTR,
   parameter logic [NB_BYTE-1:0]  ACK_BYTE  = ACK_CODE,
   parameter logic [NB_BYTE-1:0]  ERR_BYTE  = ERR_CODE
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_rx_done,
   input  logic [NB_BYTE-1:0] i_rx_data,
   input  logic               i_tx_done,
   output logic               o_tx_start,
   output logic [NB_BYTE-1:0] o_tx_data,
   output logic               o_imem_we,
   output logic [NB_ADDR-1:0] o_imem_addr,
   output logic [NB_DATA-1:0] o_imem_data,
   output logic               o_load_done,
   output logic               o_cpu_en
);

   localparam int unsigned BYTES_PER_WORD = NB_DATA / NB_BYTE;
   localparam int unsigned CNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
   localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_WORD - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MEM_WORDS - 1);

   state_t             state;
   state_t             state_nxt;
   logic [NB_DATA-1:0] word;
   logic [CNT_W-1:0]   byte_cnt;
   logic [IDX_W-1:0]   index;
   logic               skid_vld;
   logic [NB_BYTE-1:0] skid_data;
   logic [NB_BYTE-1:0] tx_data;
   logic               tx_start;

   logic               in_vld;
   logic [NB_BYTE-1:0] in_byte;
   logic               word_last;
   logic               cmd_seen;
   logic               load_end;

   // A byte parked during WRITE takes priority over a fresh tick in RECV.
   assign in_vld    = (state == ST_RECV) && (skid_vld || i_rx_done);
   assign in_byte   = skid_vld ? skid_data : i_rx_data;
   assign word_last = in_vld && (byte_cnt == CNT_LAST);
   assign cmd_seen  = i_rx_done && (i_rx_data == CMD_LOAD);
   assign load_end  = (word == HALT_WORD) || (index == IDX_LAST);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE: if (cmd_seen) state_nxt = ST_RECV;
         ST_RECV:          if (word_last) state_nxt = ST_WRITE;
         ST_WRITE:         state_nxt = load_end ? ST_ACK : ST_RECV;
         ST_ACK:           if (i_tx_done) state_nxt = ST_DONE;
         default:          state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      o_imem_we   = (state == ST_WRITE);
      o_load_done = (state == ST_DONE);
      o_cpu_en    = (state == ST_DONE);
   end

   assign o_imem_addr = NB_ADDR'({index, 2'b00});
   assign o_imem_data = word;
   assign o_tx_start  = tx_start;
   assign o_tx_data   = tx_data;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         word      <= '0;
         byte_cnt  <= '0;
         index     <= '0;
         skid_vld  <= 1'b0;
         skid_data <= '0;
         tx_data   <= '0;
         tx_start  <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (cmd_seen) begin
                  index    <= '0;
                  byte_cnt <= '0;
               end
            end
            ST_RECV: begin
               if (in_vld) begin
                  word     <= {word[NB_DATA-NB_BYTE-1:0], in_byte};
                  byte_cnt <= byte_cnt + CNT_W'(1);
               end
               // Draining the skid frees it; a tick arriving in the same cycle takes its place.
               if (skid_vld) begin
                  skid_vld  <= i_rx_done;
                  skid_data <= i_rx_data;
               end
            end
            ST_WRITE: begin
               if (load_end) begin
                  tx_data  <= (word == HALT_WORD) ? ACK_BYTE : ERR_BYTE;
                  tx_start <= 1'b1;
                  skid_vld <= 1'b0;
               end else begin
                  index <= index + IDX_W'(1);
                  if (i_rx_done) begin
                     skid_vld  <= 1'b1;
                     skid_data <= i_rx_data;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_instr_loader.sv
// Randomized scoreboard bench for uart_instr_loader: a byte-level model queues the
// expected memory writes and reply bytes, monitors pop and compare them.
module tb_uart_instr_loader;

   localparam int MW = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        rx_done = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        tx_done = 1'b0;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        load_done;
   logic        cpu_en;

   uart_instr_loader #(.MEM_WORDS(MW)) dut (
      .i_clk       (clk),
      .i_reset     (rst_n),
      .i_rx_done   (rx_done),
      .i_rx_data   (rx_data),
      .i_tx_done   (tx_done),
      .o_tx_start  (tx_start),
      .o_tx_data   (tx_data),
      .o_imem_we   (imem_we),
      .o_imem_addr (imem_addr),
      .o_imem_data (imem_data),
      .o_load_done (load_done),
      .o_cpu_en    (cpu_en)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t        wr_q[$];
   logic [7:0] tx_q[$];

   typedef enum {M_IDLE, M_LOAD, M_ACK, M_DONE} mmode_t;
   mmode_t     m_mode = M_IDLE;
   int         m_idx = 0;
   logic [7:0] m_bytes[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Host-visible behaviour: after the command, every four bytes form one word.
   task automatic model_byte(input logic [7:0] b);
      logic [31:0] w;
      case (m_mode)
         M_IDLE, M_DONE: begin
            if (b == 8'h4C) begin
               m_mode = M_LOAD;
               m_idx  = 0;
               m_bytes.delete();
            end
         end
         M_LOAD: begin
            m_bytes.push_back(b);
            if (m_bytes.size() == 4) begin
               w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
               m_bytes.delete();
               wr_q.push_back('{addr: 32'(m_idx * 4), data: w});
               if (w == 32'hFFFF_FFFF) begin
                  tx_q.push_back(8'h06);
                  m_mode = M_ACK;
               end else if (m_idx == MW - 1) begin
                  tx_q.push_back(8'h15);
                  m_mode = M_ACK;
               end else begin
                  m_idx++;
               end
            end
         end
         default: ;
      endcase
   endtask

   // Called on a falling edge; a gap of 0 makes the next byte tick in the very next cycle.
   task automatic send(input logic [7:0] b, input int gap);
      rx_done = 1'b1;
      rx_data = b;
      model_byte(b);
      @(negedge clk);
      rx_done = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w, input int last_gap);
      for (int k = 0; k < 4; k++) begin
         send(w[31-8*k -: 8], (k == 3) ? last_gap : 2);
      end
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!load_done && n < 300) begin
         @(negedge clk);
         n++;
      end
      check({name, "_load_done"}, 32'(load_done), 32'd1);
      check({name, "_cpu_en"}, 32'(cpu_en), 32'd1);
      check({name, "_pending"}, 32'(wr_q.size() + tx_q.size()), 32'd0);
      m_mode = M_DONE;
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_tx_start"}, 32'(tx_start), 32'd0);
      check({name, "_tx_data"}, 32'(tx_data), 32'd0);
      check({name, "_imem_we"}, 32'(imem_we), 32'd0);
      check({name, "_imem_addr"}, imem_addr, 32'd0);
      check({name, "_imem_data"}, imem_data, 32'd0);
      check({name, "_load_done"}, 32'(load_done), 32'd0);
      check({name, "_cpu_en"}, 32'(cpu_en), 32'd0);
   endtask

   wr_t exp_wr;

   always @(negedge clk) begin
      if (rst_n) begin
         if (imem_we) begin
            check("cpu_en_during_write", 32'(cpu_en), 32'd0);
            if (wr_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write addr=%h data=%h expected none", imem_addr, imem_data);
            end else begin
               exp_wr = wr_q.pop_front();
               check("imem_addr", imem_addr, exp_wr.addr);
               check("imem_data", imem_data, exp_wr.data);
            end
         end
         if (tx_start) begin
            if (tx_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_tx_start data=%h expected none", tx_data);
            end else begin
               check("tx_byte", 32'(tx_data), 32'(tx_q.pop_front()));
            end
         end
      end
   end

   logic [7:0] tx_held;
   int         tx_delay;

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && tx_start) begin
            tx_held  = tx_data;
            tx_delay = $urandom_range(1, 5);
            repeat (tx_delay) begin
               @(negedge clk);
               check("tx_data_hold", 32'(tx_data), 32'(tx_held));
            end
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   logic [31:0] rw;
   logic [7:0]  jb;
   int          lg;

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Basic two-word program ending on HALT.
      send(8'h4C, 2);
      send_word(32'h2008_0005, 2);
      send_word(32'hFFFF_FFFF, 2);
      wait_done("t1");

      // Junk before the command is ignored after a fresh reset.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_mode = M_IDLE;
      @(negedge clk);
      send(8'h00, 2);
      send(8'h12, 2);
      check("t2_idle_cpu_en", 32'(cpu_en), 32'd0);
      send(8'h4C, 2);
      send_word(32'h0102_0304, 2);
      send_word(32'hFFFF_FFFF, 2);
      wait_done("t2");

      // Memory fills without HALT -> ERR.
      send(8'h4C, 2);
      for (int i = 0; i < 16; i++) send(8'(i + 1), 2);
      wait_done("t3");

      // Reload from DONE: CPU drops on the command.
      send(8'h12, 1);
      check("t6_junk_cpu_en", 32'(cpu_en), 32'd1);
      send(8'h4C, 0);
      check("t6_cpu_en_drop", 32'(cpu_en), 32'd0);
      send_word(32'hABCD_EF01, 2);
      send_word(32'hFFFF_FFFF, 2);
      wait_done("t6");

      // Byte arriving in the WRITE cycle goes through the skid buffer.
      send(8'h4C, 1);
      send_word(32'h1122_3344, 0);
      send_word(32'h5566_7788, 2);
      send_word(32'hFFFF_FFFF, 2);
      wait_done("t4");

      // Reset mid-word, then a clean load from address 0.
      send(8'h4C, 1);
      send_word(32'h0A0B_0C0D, 2);
      send(8'hAA, 1);
      send(8'hBB, 1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("t5_reset");
      m_mode = M_IDLE;
      m_bytes.delete();
      wr_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(8'h4C, 2);
      send_word(32'hDEAD_BEEF, 2);
      send_word(32'hFFFF_FFFF, 2);
      wait_done("t5");

      // Randomized programs, back-to-back bytes after word ends, and occasional junk.
      for (int it = 0; it < 25; it++) begin
         if ($urandom_range(0, 1) == 1) begin
            jb = 8'($urandom);
            if (jb == 8'h4C) jb = 8'h00;
            send(jb, 1);
            check("rand_junk_cpu_en", 32'(cpu_en), 32'd1);
         end
         send(8'h4C, $urandom_range(1, 3));
         lg = 1;
         while (m_mode == M_LOAD) begin
            rw = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            for (int k = 0; k < 4; k++) begin
               lg = (k == 3) ? $urandom_range(0, 3) : $urandom_range(1, 3);
               send(rw[31-8*k -: 8], lg);
            end
         end
         if (lg == 0) send(8'($urandom), 1);
         wait_done("rand");
      end

      check("final_pending", 32'(wr_q.size() + tx_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
